// File: rtl/min_scheduler.sv
// Round-robin front end that time-shares one FindMin unit among NUM_REQ requesters.
// Each grant runs FindMin through load, run, clear and respond; the result is tagged with the requester id.
//   state   | meaning
//   S_IDLE  | arbitrate from ptr, capture the winner's vector
//   S_LOAD  | grant pulse, advance ptr, clear timeout counter
//   S_RUN   | min_start held, wait for min_done or timeout
//   S_CLEAR | FindMin held in clear for one cycle
//   S_RESP  | resp_valid pulse, back to idle
module min_scheduler #(
  parameter  int NUM_REQ  = 4,
  parameter  int DATA_W   = 16,
  parameter  int NUM_ELEM = 8,
  parameter  int TIMEOUT  = 64,
  localparam int IDW      = $clog2(NUM_REQ),
  localparam int VW       = NUM_ELEM * DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*VW-1:0]     req_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  output logic                      resp_valid,
  output logic [IDW-1:0]            resp_id,
  output logic [DATA_W-1:0]         resp_min,
  output logic                      resp_err,
  output logic [VW-1:0]             min_numbers,
  output logic                      min_start,
  output logic                      min_rst_n,
  input  logic                      min_done,
  input  logic [DATA_W-1:0]         min_result
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0]      TCNT_LAST = TW'(TIMEOUT - 1);
  localparam logic [IDW-1:0]     ID_LAST   = IDW'(NUM_REQ - 1);
  localparam logic [IDW:0]       NREQ_W    = (IDW + 1)'(NUM_REQ);
  localparam logic [NUM_REQ-1:0] GRANT_ONE = NUM_REQ'(1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_CLEAR, S_RESP} state_t;

  state_t              state_q;
  logic [IDW-1:0]      ptr_q;
  logic [IDW-1:0]      sel_q;
  logic [TW-1:0]       tcnt_q;
  logic [DATA_W-1:0]   res_q;
  logic                err_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic                busy_q;
  logic                resp_valid_q;
  logic [IDW-1:0]      resp_id_q;
  logic [DATA_W-1:0]   resp_min_q;
  logic                resp_err_q;
  logic [VW-1:0]       min_numbers_q;
  logic                min_start_q;
  logic                min_rst_n_q;

  logic                arb_hit_d;
  logic [IDW-1:0]      arb_id_d;
  logic [IDW:0]        cand_w;

  // Walk from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    arb_hit_d = 1'b0;
    arb_id_d  = ptr_q;
    cand_w    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_w = {1'b0, ptr_q} + (IDW + 1)'(k);
      if (cand_w >= NREQ_W) cand_w = cand_w - NREQ_W;
      if (req[cand_w[IDW-1:0]]) begin
        arb_hit_d = 1'b1;
        arb_id_d  = cand_w[IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ptr_q         <= '0;
      sel_q         <= '0;
      tcnt_q        <= '0;
      res_q         <= '0;
      err_q         <= 1'b0;
      grant_q       <= '0;
      busy_q        <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_min_q    <= '0;
      resp_err_q    <= 1'b0;
      min_numbers_q <= '0;
      min_start_q   <= 1'b0;
      min_rst_n_q   <= 1'b0;
    end else begin
      grant_q      <= '0;
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          min_rst_n_q <= 1'b1;
          if (arb_hit_d) begin
            sel_q         <= arb_id_d;
            min_numbers_q <= req_data[int'(arb_id_d)*VW +: VW];
            grant_q       <= GRANT_ONE << arb_id_d;
            busy_q        <= 1'b1;
            state_q       <= S_LOAD;
          end
        end
        S_LOAD: begin
          ptr_q       <= (sel_q == ID_LAST) ? '0 : sel_q + 1'b1;
          tcnt_q      <= '0;
          min_start_q <= 1'b1;
          state_q     <= S_RUN;
        end
        S_RUN: begin
          if (min_done) begin
            res_q       <= min_result;
            err_q       <= 1'b0;
            min_start_q <= 1'b0;
            min_rst_n_q <= 1'b0;
            state_q     <= S_CLEAR;
          end else if (tcnt_q == TCNT_LAST) begin
            res_q       <= '0;
            err_q       <= 1'b1;
            min_start_q <= 1'b0;
            min_rst_n_q <= 1'b0;
            state_q     <= S_CLEAR;
          end else begin
            tcnt_q <= tcnt_q + 1'b1;
          end
        end
        S_CLEAR: begin
          min_rst_n_q  <= 1'b1;
          resp_valid_q <= 1'b1;
          resp_id_q    <= sel_q;
          resp_min_q   <= res_q;
          resp_err_q   <= err_q;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign busy        = busy_q;
  assign resp_valid  = resp_valid_q;
  assign resp_id     = resp_id_q;
  assign resp_min    = resp_min_q;
  assign resp_err    = resp_err_q;
  assign min_numbers = min_numbers_q;
  assign min_start   = min_start_q;
  assign min_rst_n   = min_rst_n_q;

endmodule

// File: tb/tb_min_scheduler.sv
// Bench for min_scheduler: a FindMin model with programmable latency and a round-robin
// reference that predicts grant order, captured vector, minimum and response timing.
module tb_min_scheduler;
  localparam int NR  = 4;
  localparam int DW  = 16;
  localparam int NE  = 8;
  localparam int TO  = 64;
  localparam int VW  = NE * DW;
  localparam int IDW = $clog2(NR);

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [NR*VW-1:0]  req_data;
  logic [NR-1:0]     grant;
  logic              busy, resp_valid, resp_err, min_start, min_rst_n;
  logic [IDW-1:0]    resp_id;
  logic [DW-1:0]     resp_min;
  logic [VW-1:0]     min_numbers;
  logic              min_done = 1'b0;
  logic [DW-1:0]     min_result = '0;

  int n_cmp  = 0;
  int n_fail = 0;
  int ptr_m  = 0;
  int done_lat = 1;
  int fm_cnt = 0;
  bit never_done = 1'b0;
  bit spurious   = 1'b0;

  typedef struct packed {
    logic [NR-1:0] g;
    int            glat;
    logic [VW-1:0] nums;
    logic          busy_g;
    int            rlat;
    int            st_cnt;
    int            rl_cnt;
    logic [IDW-1:0] rid;
    logic [DW-1:0] rmin;
    logic          rerr;
    bit            pulse_ok;
  } obs_t;

  typedef struct packed {
    int            e;
    logic [NR-1:0] g;
    logic [VW-1:0] nums;
    logic [DW-1:0] rmin;
    logic          err;
    int            len;
  } exp_t;

  min_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .NUM_ELEM(NE), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .grant(grant), .busy(busy),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_min(resp_min), .resp_err(resp_err),
    .min_numbers(min_numbers), .min_start(min_start), .min_rst_n(min_rst_n),
    .min_done(min_done), .min_result(min_result)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] vec_min(input logic [VW-1:0] v);
    logic [DW-1:0] m;
    m = v[DW-1:0];
    for (int k = 1; k < NE; k++) if (v[k*DW +: DW] < m) m = v[k*DW +: DW];
    return m;
  endfunction

  function automatic int rr_pick(input int p, input logic [NR-1:0] r);
    for (int k = 0; k < NR; k++) if (r[(p + k) % NR]) return (p + k) % NR;
    return 0;
  endfunction

  // FindMin stand-in: done after done_lat cycles of start, cleared by min_rst_n.
  always @(negedge clk) begin
    if (spurious) begin
      min_done   = 1'b1;
      min_result = 16'hBEEF;
    end else if (min_rst_n !== 1'b1) begin
      fm_cnt   = 0;
      min_done = 1'b0;
    end else if (min_start === 1'b1) begin
      fm_cnt++;
      if (!never_done && fm_cnt >= done_lat) begin
        min_done   = 1'b1;
        min_result = vec_min(min_numbers);
      end
    end else begin
      fm_cnt   = 0;
      min_done = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random();
    for (int w = 0; w < NR*VW/32; w++) req_data[w*32 +: 32] = $urandom();
  endtask

  task automatic wait_for_grant(output int n);
    n = 0;
    do begin tick(); n++; end while (grant == '0 && n < 20);
  endtask

  task automatic wait_for_resp(output int n);
    n = 0;
    do begin tick(); n++; end while (!resp_valid && n < 300);
  endtask

  task automatic predict(input logic [NR-1:0] mask, input int lat, output exp_t x);
    x      = '0;
    x.e    = rr_pick(ptr_m, mask);
    x.g[x.e] = 1'b1;
    ptr_m  = (x.e + 1) % NR;
    x.nums = req_data[x.e*VW +: VW];
    x.err  = never_done || (lat > TO);
    x.len  = x.err ? TO : lat;
    x.rmin = x.err ? '0 : vec_min(x.nums);
  endtask

  task automatic serve(input logic [NR-1:0] mask, input int lat, input bit hold, output obs_t o);
    o = '0;
    req = mask;
    done_lat = lat;
    wait_for_grant(o.glat);
    o.g = grant; o.nums = min_numbers; o.busy_g = busy;
    if (!hold) req = '0;
    o.pulse_ok = 1'b1;
    do begin
      tick(); o.rlat++;
      if (o.rlat == 1 && grant != '0) o.pulse_ok = 1'b0;
      if (min_start) o.st_cnt++;
      if (!min_rst_n) o.rl_cnt++;
    end while (!resp_valid && o.rlat < 300);
    o.rid = resp_id; o.rmin = resp_min; o.rerr = resp_err;
    tick();
    if (resp_valid || busy || resp_id !== o.rid || resp_min !== o.rmin || resp_err !== o.rerr)
      o.pulse_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; req_data = '0;
    repeat (3) tick();
    n_cmp++;
    if ({grant, busy, resp_valid, resp_id, resp_min, resp_err, min_start, min_rst_n} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0",
        {grant, busy, resp_valid, resp_id, resp_min, resp_err, min_start, min_rst_n});
    end
    n_cmp++;
    if (min_numbers !== '0) begin n_fail++; $display("FAIL reset_numbers: got %h want 0", min_numbers); end
    rst = 1'b0; ptr_m = 0;
    tick();
    n_cmp++;
    if (min_rst_n !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: min_rst_n=%b busy=%b want 1/0", min_rst_n, busy);
    end
  endtask

  task automatic test_round_robin();
    obs_t o; exp_t x;
    fill_random();
    for (int i = 0; i < 8; i++) begin
      predict(4'b1111, $urandom_range(1, 6), x);
      serve(4'b1111, x.len, 1'b1, o);
      n_cmp++;
      if (o.g !== x.g) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b want %b", i, o.g, x.g); end
      n_cmp++;
      if (o.nums !== x.nums) begin n_fail++; $display("FAIL rr_numbers[%0d]: got %h want %h", i, o.nums, x.nums); end
      n_cmp++;
      if ({o.rid, o.rmin, o.rerr} !== {IDW'(x.e), x.rmin, x.err}) begin
        n_fail++; $display("FAIL rr_resp[%0d]: got id=%0d min=%h err=%b want id=%0d min=%h err=%b",
          i, o.rid, o.rmin, o.rerr, x.e, x.rmin, x.err);
      end
      n_cmp++;
      if (o.glat != 1 || o.rlat != x.len + 2 || o.st_cnt != x.len || o.rl_cnt != 1 || !o.pulse_ok) begin
        n_fail++; $display("FAIL rr_timing[%0d]: glat=%0d rlat=%0d start=%0d clr=%0d pulse=%0b want 1/%0d/%0d/1/1",
          i, o.glat, o.rlat, o.st_cnt, o.rl_cnt, o.pulse_ok, x.len + 2, x.len);
      end
    end
    req = '0;
    tick();
  endtask

  task automatic test_idle_done();
    int seen;
    seen = 0;
    spurious = 1'b1;
    repeat (6) begin tick(); if (busy || resp_valid || grant != '0 || min_start) seen++; end
    spurious = 1'b0;
    repeat (2) begin tick(); if (busy || resp_valid || grant != '0 || min_start) seen++; end
    n_cmp++;
    if (seen != 0) begin n_fail++; $display("FAIL idle_done_ignored: %0d active cycles want 0", seen); end
  endtask

  task automatic test_single();
    obs_t o; exp_t x;
    logic [DW-1:0] t1 [NE];
    t1 = '{16'h0030, 16'h0012, 16'h7FFF, 16'h0005, 16'h0100, 16'h0044, 16'h0009, 16'h0020};
    fill_random();
    for (int k = 0; k < NE; k++) req_data[k*DW +: DW] = t1[k];
    predict(4'b0001, 3, x);
    serve(4'b0001, 3, 1'b0, o);
    n_cmp++;
    if (o.g !== 4'b0001 || o.busy_g !== 1'b1) begin
      n_fail++; $display("FAIL single_grant: got %b busy=%b want 0001 busy=1", o.g, o.busy_g);
    end
    n_cmp++;
    if (o.nums !== x.nums) begin n_fail++; $display("FAIL single_numbers: got %h want %h", o.nums, x.nums); end
    n_cmp++;
    if ({o.rid, o.rmin, o.rerr} !== {2'd0, 16'h0005, 1'b0}) begin
      n_fail++; $display("FAIL single_resp: got id=%0d min=%h err=%b want 0/0005/0", o.rid, o.rmin, o.rerr);
    end
    n_cmp++;
    if (o.glat != 1 || o.rlat != 5 || o.rl_cnt != 1 || !o.pulse_ok) begin
      n_fail++; $display("FAIL single_timing: glat=%0d rlat=%0d clr=%0d pulse=%0b want 1/5/1/1",
        o.glat, o.rlat, o.rl_cnt, o.pulse_ok);
    end
  endtask

  task automatic test_random();
    obs_t o; exp_t x;
    logic [NR-1:0] mask;
    int lat;
    for (int i = 0; i < 12; i++) begin
      fill_random();
      mask = NR'($urandom_range(1, (1 << NR) - 1));
      lat  = $urandom_range(1, 12);
      predict(mask, lat, x);
      serve(mask, lat, 1'b0, o);
      n_cmp++;
      if (o.g !== x.g) begin n_fail++; $display("FAIL rand_grant[%0d]: mask=%b got %b want %b", i, mask, o.g, x.g); end
      n_cmp++;
      if (o.nums !== x.nums) begin n_fail++; $display("FAIL rand_numbers[%0d]: got %h want %h", i, o.nums, x.nums); end
      n_cmp++;
      if ({o.rid, o.rmin, o.rerr} !== {IDW'(x.e), x.rmin, x.err}) begin
        n_fail++; $display("FAIL rand_resp[%0d]: got id=%0d min=%h err=%b want id=%0d min=%h err=%b",
          i, o.rid, o.rmin, o.rerr, x.e, x.rmin, x.err);
      end
      n_cmp++;
      if (o.glat != 1 || o.rlat != x.len + 2 || o.st_cnt != x.len || o.rl_cnt != 1 || !o.pulse_ok) begin
        n_fail++; $display("FAIL rand_timing[%0d]: glat=%0d rlat=%0d start=%0d clr=%0d pulse=%0b want 1/%0d/%0d/1/1",
          i, o.glat, o.rlat, o.st_cnt, o.rl_cnt, o.pulse_ok, x.len + 2, x.len);
      end
    end
  endtask

  task automatic test_late_arrival();
    exp_t x; obs_t o;
    int n;
    fill_random();
    predict(4'b0100, 5, x);
    req = 4'b0100; done_lat = 5;
    wait_for_grant(n);
    n_cmp++;
    if (grant !== x.g) begin n_fail++; $display("FAIL late_grant_a: got %b want %b", grant, x.g); end
    tick(); tick();
    req = 4'b1000;
    wait_for_resp(n);
    n_cmp++;
    if ({resp_valid, resp_id, resp_min, resp_err} !== {1'b1, IDW'(x.e), x.rmin, 1'b0}) begin
      n_fail++; $display("FAIL late_resp_a: got v=%b id=%0d min=%h err=%b want 1/%0d/%h/0",
        resp_valid, resp_id, resp_min, resp_err, x.e, x.rmin);
    end
    predict(4'b1000, 5, x);
    wait_for_grant(n);
    n_cmp++;
    if (grant !== x.g) begin n_fail++; $display("FAIL late_grant_b: got %b want %b", grant, x.g); end
    req = '0;
    wait_for_resp(n);
    n_cmp++;
    if ({resp_valid, resp_id, resp_min} !== {1'b1, IDW'(x.e), x.rmin}) begin
      n_fail++; $display("FAIL late_resp_b: got v=%b id=%0d min=%h want 1/%0d/%h", resp_valid, resp_id, resp_min, x.e, x.rmin);
    end
    tick();
    predict(4'b1001, 2, x);
    serve(4'b1001, 2, 1'b0, o);
    n_cmp++;
    if (o.g !== x.g || o.rid !== IDW'(x.e)) begin
      n_fail++; $display("FAIL late_ptr_wrap: got grant=%b id=%0d want %b/%0d", o.g, o.rid, x.g, x.e);
    end
  endtask

  task automatic test_timeout();
    obs_t o; exp_t x;
    fill_random();
    for (int i = 0; i < 2; i++) begin
      never_done = (i == 0);
      predict(4'b0010, TO + 1, x);
      serve(4'b0010, TO + 1, 1'b0, o);
      n_cmp++;
      if ({o.rid, o.rmin, o.rerr} !== {IDW'(x.e), 16'h0000, 1'b1}) begin
        n_fail++; $display("FAIL timeout_resp[%0d]: got id=%0d min=%h err=%b want %0d/0000/1", i, o.rid, o.rmin, o.rerr, x.e);
      end
      n_cmp++;
      if (o.st_cnt != TO || o.rl_cnt != 1 || o.rlat != TO + 2 || !o.pulse_ok) begin
        n_fail++; $display("FAIL timeout_timing[%0d]: start=%0d clr=%0d rlat=%0d pulse=%0b want %0d/1/%0d/1",
          i, o.st_cnt, o.rl_cnt, o.rlat, o.pulse_ok, TO, TO + 2);
      end
    end
    never_done = 1'b0;
    predict(4'b0100, 2, x);
    serve(4'b0100, 2, 1'b0, o);
    n_cmp++;
    if ({o.g, o.rid, o.rmin, o.rerr} !== {x.g, IDW'(x.e), x.rmin, 1'b0}) begin
      n_fail++; $display("FAIL timeout_recover: got g=%b id=%0d min=%h err=%b want %b/%0d/%h/0",
        o.g, o.rid, o.rmin, o.rerr, x.g, x.e, x.rmin);
    end
  endtask

  task automatic test_coincident();
    obs_t o; exp_t x;
    fill_random();
    predict(4'b1000, TO, x);
    serve(4'b1000, TO, 1'b0, o);
    n_cmp++;
    if ({o.rid, o.rmin, o.rerr} !== {IDW'(x.e), x.rmin, 1'b0}) begin
      n_fail++; $display("FAIL coincident_resp: got id=%0d min=%h err=%b want %0d/%h/0", o.rid, o.rmin, o.rerr, x.e, x.rmin);
    end
    n_cmp++;
    if (o.st_cnt != TO || o.rlat != TO + 2) begin
      n_fail++; $display("FAIL coincident_timing: start=%0d rlat=%0d want %0d/%0d", o.st_cnt, o.rlat, TO, TO + 2);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o; exp_t x;
    int n, seen;
    fill_random();
    req = 4'b0100; done_lat = 40;
    wait_for_grant(n);
    n_cmp++;
    if (grant !== 4'b0100) begin n_fail++; $display("FAIL rstmid_grant: got %b want 0100", grant); end
    req = '0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({grant, busy, resp_valid, resp_id, resp_min, resp_err, min_start, min_rst_n} !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %h want 0",
        {grant, busy, resp_valid, resp_id, resp_min, resp_err, min_start, min_rst_n});
    end
    n_cmp++;
    if (min_numbers !== '0) begin n_fail++; $display("FAIL rstmid_numbers: got %h want 0", min_numbers); end
    rst = 1'b0; ptr_m = 0;
    seen = 0;
    repeat (80) begin tick(); if (resp_valid || grant != '0 || busy) seen++; end
    n_cmp++;
    if (seen != 0) begin n_fail++; $display("FAIL rstmid_dropped: %0d active cycles want 0", seen); end
    predict(4'b1010, 4, x);
    serve(4'b1010, 4, 1'b0, o);
    n_cmp++;
    if ({o.g, o.rid, o.rmin, o.rerr} !== {x.g, IDW'(x.e), x.rmin, 1'b0} || o.rlat != 6) begin
      n_fail++; $display("FAIL rstmid_next: got g=%b id=%0d min=%h err=%b rlat=%0d want %b/%0d/%h/0/6",
        o.g, o.rid, o.rmin, o.rerr, o.rlat, x.g, x.e, x.rmin);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_idle_done();
    test_single();
    test_random();
    test_late_arrival();
    test_timeout();
    test_coincident();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached after %0d comparisons", n_cmp);
    $fatal(1);
  end

endmodule
